hazard_forward_unit: RTL and testbench

Parametrised forwarding and load-use hazard unit for the pipelined core. It tracks in-flight destination registers internally in its own shadow pipeline, so the datapath no longer wires stage-latch fields into it. From the decode-stage operands it does two things: it raises a same-cycle stall on load-use hazards, and it registers the EX-stage operand mux selects for any forwarding depth. It sits beside the ID/EX latch and drives the EX operand muxes and the PC/IF-ID write-enables.

---
 rtl/hazard_pkg.sv | 23 ++
 rtl/hazard_match.sv | 44 ++++
 rtl/hazard_forward_unit.sv | 115 +++++++++++
 tb/tb_hazard_forward_unit.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared types and constants for the forwarding / load-use hazard unit.
package hazard_pkg;

  // Operand select value meaning "read the register file".
  localparam int unsigned FWD_RF = 0;

  // Widest register index supported; narrower indices are zero-extended into dest.
  localparam int unsigned MaxAddrW = 8;

  // One shadow-pipeline entry.
  typedef struct packed {
    logic                valid;
    logic [MaxAddrW-1:0] dest;
    logic                reg_write;
    logic                mem_read;
  } stage_t;

  // Width of an operand select able to name sources 0..depth.
  function automatic int unsigned sel_w(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Youngest-producer priority encoder for one decode-stage source operand.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned LOAD_SRC  = 2,
  parameter bit          ZERO_REG  = 1'b0,
  localparam int unsigned SEL_W    = sel_w(FWD_DEPTH)
) (
  input  stage_t            stage_i [FWD_DEPTH],
  input  logic [ADDR_W-1:0] idx_i,
  input  logic              used_i,
  output logic [SEL_W-1:0]  sel_o,
  output logic              hazard_o
);

  logic [MaxAddrW-1:0]  idx_ext;
  logic [FWD_DEPTH-1:0] hit;

  assign idx_ext = MaxAddrW'(idx_i);

  // Per-stage match: live register writer of the operand we actually read.
  always_comb begin
    hit = '0;
    for (int j = 0; j < int'(FWD_DEPTH); j++) begin
      hit[j] = used_i && stage_i[j].valid && stage_i[j].reg_write &&
               (stage_i[j].dest == idx_ext) && !(ZERO_REG && (idx_ext == '0));
    end
  end

  // Walk oldest to youngest so the youngest hit overrides; stage j becomes source j+1.
  always_comb begin
    sel_o    = SEL_W'(FWD_RF);
    hazard_o = 1'b0;
    for (int j = int'(FWD_DEPTH) - 1; j >= 0; j--) begin
      if (hit[j]) begin
        sel_o    = SEL_W'(j + 1);
        hazard_o = stage_i[j].mem_read && ((j + 1) < int'(LOAD_SRC));
      end
    end
  end

endmodule

// File: rtl/hazard_forward_unit.sv
// Forwarding select and load-use stall generator with an internal shadow pipeline
// of in-flight destinations. Stage 0 is EX; stage j reaches forwarding source j+1.
// A producer at stage FWD_DEPTH has written the register file already, so only
// stages 0..FWD_DEPTH-1 are kept.
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int unsigned ADDR_W    = 2,
  parameter int unsigned FWD_DEPTH = 2,
  parameter int unsigned LOAD_SRC  = 2,
  parameter bit          ZERO_REG  = 1'b0,
  parameter int unsigned CNT_W     = 16,
  localparam int unsigned SEL_W    = sel_w(FWD_DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [ADDR_W-1:0] id_rs,
  input  logic [ADDR_W-1:0] id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [ADDR_W-1:0] id_dest,
  input  logic              id_reg_write,
  input  logic              id_mem_read,
  input  logic              flush,
  output logic              stall,
  output logic [SEL_W-1:0]  fwd_a,
  output logic [SEL_W-1:0]  fwd_b,
  output logic [CNT_W-1:0]  stall_count
);

  stage_t             stage_q [FWD_DEPTH];
  stage_t             stage_d [FWD_DEPTH];
  logic [SEL_W-1:0]   fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_a, sel_b;
  logic               haz_a, haz_b;
  logic               load_ex;

  hazard_match #(
    .ADDR_W   (ADDR_W),
    .FWD_DEPTH(FWD_DEPTH),
    .LOAD_SRC (LOAD_SRC),
    .ZERO_REG (ZERO_REG)
  ) u_match_rs (
    .stage_i (stage_q),
    .idx_i   (id_rs),
    .used_i  (id_rs_used),
    .sel_o   (sel_a),
    .hazard_o(haz_a)
  );

  hazard_match #(
    .ADDR_W   (ADDR_W),
    .FWD_DEPTH(FWD_DEPTH),
    .LOAD_SRC (LOAD_SRC),
    .ZERO_REG (ZERO_REG)
  ) u_match_rt (
    .stage_i (stage_q),
    .idx_i   (id_rt),
    .used_i  (id_rt_used),
    .sel_o   (sel_b),
    .hazard_o(haz_b)
  );

  // Same-cycle stall; flush and reset both suppress it.
  always_comb begin
    stall   = id_valid && !flush && !reset && (haz_a || haz_b);
    load_ex = id_valid && !stall && !flush;
  end

  // Next state: shift the shadow pipeline, load EX or a bubble, count stalls.
  always_comb begin
    stage_d[0] = '0;
    if (load_ex) begin
      stage_d[0].valid     = 1'b1;
      stage_d[0].dest      = MaxAddrW'(id_dest);
      stage_d[0].reg_write = id_reg_write;
      stage_d[0].mem_read  = id_mem_read;
    end
    for (int i = 1; i < int'(FWD_DEPTH); i++) begin
      stage_d[i] = stage_q[i-1];
    end
    fwd_a_d = load_ex ? sel_a : SEL_W'(FWD_RF);
    fwd_b_d = load_ex ? sel_b : SEL_W'(FWD_RF);
    cnt_d   = cnt_q;
    if (stall && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(FWD_DEPTH); i++) begin
        stage_q[i] <= '0;
      end
      fwd_a_q <= SEL_W'(FWD_RF);
      fwd_b_q <= SEL_W'(FWD_RF);
      cnt_q   <= '0;
    end else begin
      for (int i = 0; i < int'(FWD_DEPTH); i++) begin
        stage_q[i] <= stage_d[i];
      end
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign fwd_a       = fwd_a_q;
  assign fwd_b       = fwd_b_q;
  assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Bench: two configurations driven by one ID stream, each checked against an
// age-indexed history model of instructions that entered EX.
module tb_hazard_forward_unit;

  localparam int AW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1, id_valid = 1'b0, flush = 1'b0;
  logic [AW-1:0] id_rs = '0, id_rt = '0, id_dest = '0;
  logic          id_rs_used = 1'b0, id_rt_used = 1'b0;
  logic          id_reg_write = 1'b0, id_mem_read = 1'b0;

  logic        stall0, stall1;
  logic [1:0]  fa0, fb0, fa1, fb1;
  logic [3:0]  cnt0;
  logic [15:0] cnt1;

  // Defaults with a short counter so saturation is reachable.
  hazard_forward_unit #(.CNT_W(4)) dut0 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall0), .fwd_a(fa0), .fwd_b(fb0), .stall_count(cnt0)
  );

  hazard_forward_unit #(.FWD_DEPTH(3), .LOAD_SRC(3), .ZERO_REG(1'b1)) dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .flush(flush),
    .stall(stall1), .fwd_a(fa1), .fwd_b(fb1), .stall_count(cnt1)
  );

  typedef struct {
    bit v;
    int dest;
    bit rw;
    bit mr;
  } ins_t;

  int   depth [2] = '{2, 3};
  int   lsrc  [2] = '{2, 3};
  bit   zr    [2] = '{1'b0, 1'b1};
  int   cw    [2] = '{4, 16};

  ins_t hist [2][4];  // hist[d][k]: instruction that entered EX k cycles ago
  int   exp_fa [2] = '{0, 0};
  int   exp_fb [2] = '{0, 0};
  int   exp_cnt[2] = '{0, 0};
  bit   exp_stall[2] = '{1'b0, 1'b0};

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input int d, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s dut%0d t=%0t observed=%0d expected=%0d", tag, d, $time, obs, exp);
    end
  endtask

  // Youngest in-flight writer of idx among the forwardable ages.
  task automatic cand(input int d, input int idx, input bit used, output int sel,
                      output bit haz);
    sel = 0;
    haz = 1'b0;
    if (!used || (zr[d] && idx == 0)) return;
    for (int j = 0; j < depth[d]; j++) begin
      if (hist[d][j].v && hist[d][j].rw && hist[d][j].dest == idx) begin
        sel = j + 1;
        haz = hist[d][j].mr && (j + 1 < lsrc[d]);
        return;
      end
    end
  endtask

  task automatic tick();
    int sa, sb;
    bit ha, hb, ld;
    #2;
    for (int d = 0; d < 2; d++) begin
      cand(d, int'(id_rs), id_rs_used, sa, ha);
      cand(d, int'(id_rt), id_rt_used, sb, hb);
      exp_stall[d] = id_valid && !flush && !reset && (ha || hb);
      chk("stall", d, (d == 0) ? int'(stall0) : int'(stall1), int'(exp_stall[d]));
      ld = id_valid && !exp_stall[d] && !flush;
      if (reset) begin
        for (int k = 0; k < 4; k++) hist[d][k] = '{1'b0, 0, 1'b0, 1'b0};
        exp_fa[d]  = 0;
        exp_fb[d]  = 0;
        exp_cnt[d] = 0;
      end else begin
        for (int k = 3; k > 0; k--) hist[d][k] = hist[d][k-1];
        if (ld) hist[d][0] = '{1'b1, int'(id_dest), id_reg_write, id_mem_read};
        else    hist[d][0] = '{1'b0, 0, 1'b0, 1'b0};
        exp_fa[d] = ld ? sa : 0;
        exp_fb[d] = ld ? sb : 0;
        if (exp_stall[d] && exp_cnt[d] < (1 << cw[d]) - 1) exp_cnt[d]++;
      end
    end
    @(posedge clk);
    #1;
    chk("fwd_a", 0, int'(fa0), exp_fa[0]);
    chk("fwd_b", 0, int'(fb0), exp_fb[0]);
    chk("count", 0, int'(cnt0), exp_cnt[0]);
    chk("fwd_a", 1, int'(fa1), exp_fa[1]);
    chk("fwd_b", 1, int'(fb1), exp_fb[1]);
    chk("count", 1, int'(cnt1), exp_cnt[1]);
  endtask

  task automatic issue(input bit v, input int rs, input int rt, input bit ru, input bit tu,
                       input int dst, input bit rw, input bit mr, input bit fl);
    id_valid     = v;
    id_rs        = AW'(rs);
    id_rt        = AW'(rt);
    id_rs_used   = ru;
    id_rt_used   = tu;
    id_dest      = AW'(dst);
    id_reg_write = rw;
    id_mem_read  = mr;
    flush        = fl;
    tick();
  endtask

  task automatic nop();
    issue(1'b0, 0, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset state.
    reset = 1'b1;
    nop();
    nop();
    reset = 1'b0;
    nop();

    // ADD r1 then ADD r2<-r1,r3: no stall, fwd_a = 1.
    issue(1, 2, 3, 1, 1, 1, 1, 0, 0);
    issue(1, 1, 3, 1, 1, 2, 1, 0, 0);
    nop(); nop(); nop();

    // LW r1 then ADD r2<-r1,r1: one stall on defaults, hold until accepted.
    issue(1, 0, 2, 1, 0, 1, 1, 1, 0);
    issue(1, 1, 1, 1, 1, 2, 1, 0, 0);
    for (int k = 0; k < 4 && exp_stall[0]; k++) issue(1, 1, 1, 1, 1, 2, 1, 0, 0);
    nop(); nop(); nop();

    // Two producers of r2: the younger wins.
    issue(1, 0, 0, 0, 0, 2, 1, 0, 0);
    issue(1, 0, 0, 0, 0, 2, 1, 0, 0);
    issue(1, 2, 2, 1, 1, 3, 1, 0, 0);
    nop(); nop(); nop();

    // Flush beats a load-use hazard.
    issue(1, 0, 0, 0, 0, 1, 1, 1, 0);
    issue(1, 1, 1, 1, 1, 2, 1, 0, 1);
    nop(); nop(); nop();

    // Writer of r0 then reader of r0: forwarded only without a zero register.
    issue(1, 0, 0, 0, 0, 0, 1, 0, 0);
    issue(1, 0, 0, 1, 1, 3, 1, 0, 0);
    nop(); nop(); nop();

    // Deep configuration: load then immediate consumer, held until accepted.
    issue(1, 0, 0, 0, 0, 1, 1, 1, 0);
    issue(1, 1, 3, 1, 1, 2, 1, 0, 0);
    for (int k = 0; k < 4 && exp_stall[1]; k++) issue(1, 1, 3, 1, 1, 2, 1, 0, 0);
    nop(); nop(); nop();

    // Dependent pair far apart: select 0.
    issue(1, 0, 0, 0, 0, 3, 1, 0, 0);
    nop(); nop(); nop(); nop();
    issue(1, 3, 3, 1, 1, 2, 1, 0, 0);
    nop();

    // Reset asserted during a load-use stall.
    issue(1, 0, 0, 0, 0, 1, 1, 1, 0);
    issue(1, 1, 0, 1, 0, 2, 1, 0, 0);
    reset = 1'b1;
    issue(1, 1, 0, 1, 0, 2, 1, 0, 0);
    reset = 1'b0;
    issue(1, 1, 0, 1, 0, 2, 1, 0, 0);
    nop(); nop(); nop();

    // Many load-use pairs: short counter saturates at all-ones.
    for (int k = 0; k < 21; k++) begin
      issue(1, 0, 0, 0, 0, 1, 1, 1, 0);
      issue(1, 1, 1, 1, 1, 2, 1, 0, 0);
    end
    nop(); nop(); nop();

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 39) == 0);
      issue($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 3),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
            $urandom_range(0, 7) == 0);
    end
    reset = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
